// File: rtl/valid_delay_line.sv
// valid_delay_line: delays a valid strobe plus its data word and user sideband
// by DEPTH enabled clock cycles. Supports ce stalling and a synchronous flush.
// Optional occupancy counter (inflight/busy) is built when the macro
// VALID_DELAY_LINE_CNT_EN is defined.
module valid_delay_line #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned USER_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [USER_W-1:0] in_user,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [USER_W-1:0] out_user
`ifdef VALID_DELAY_LINE_CNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] inflight,
    output logic                       busy
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              valid_q [DEPTH];
    logic              valid_d [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [DATA_W-1:0] data_d  [DEPTH];
    logic [USER_W-1:0] user_q  [DEPTH];
    logic [USER_W-1:0] user_d  [DEPTH];

    // Next-state of the stage chain: flush kills valids, ce shifts everything.
    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k];
            data_d[k]  = data_q[k];
            user_d[k]  = user_q[k];
        end
        if (flush) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                valid_d[k] = 1'b0;
            end
        end else if (ce) begin
            valid_d[0] = in_valid;
            data_d[0]  = in_data;
            user_d[0]  = in_user;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                valid_d[k] = valid_q[k-1];
                data_d[k]  = data_q[k-1];
                user_d[k]  = user_q[k-1];
            end
        end
    end

    // Stage registers; reset empties the line and clears the payload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
                user_q[k]  <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                valid_q[k] <= valid_d[k];
                data_q[k]  <= data_d[k];
                user_q[k]  <= user_d[k];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign out_user  = user_q[DEPTH-1];

`ifdef VALID_DELAY_LINE_CNT_EN
    logic [CNT_W-1:0] inflight_q;
    logic [CNT_W-1:0] inflight_d;

    // Occupancy: one in, one out per enabled cycle; flush empties the line.
    always_comb begin
        inflight_d = inflight_q;
        if (flush) begin
            inflight_d = '0;
        end else if (ce) begin
            inflight_d = inflight_q + CNT_W'(in_valid) - CNT_W'(valid_q[DEPTH-1]);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign inflight = inflight_q;
    assign busy     = (inflight_q != '0);
`endif

endmodule
